alu_issue_arbiter: RTL and testbench

Shares the single registered `alu` execute datapath between two requesters: port 0 (main issue pipeline) and port 1 (auxiliary address/compare unit). Each cycle it selects at most one request using round-robin priority, steers that request's operands and one-hot opcode/ALU vectors into the ALU, and returns the ALU's registered result one cycle later with the requester ID and destination tag. Result backpressure is handled without a skid buffer: while a result is stalled, the ALU receives an all-zero ALU-op vector, so `alu_value` holds its value.

---
 rtl/alu_issue_arbiter_if.sv | 70 +++++++
 rtl/alu_issue_arbiter.sv | 105 ++++++++++
 tb/tb_alu_issue_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_arbiter_if.sv
// Signal bundle between the two ALU requesters, the shared ALU and the result consumer.
// Handshake: a request transfers on a clock edge where valid and ready are both high; rsp likewise.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif

interface alu_issue_arbiter_if #(
    parameter int DWIDTH   = 32,
    parameter int PC_WIDTH = 32,
    parameter int AWIDTH   = 5
);
    logic                     rq0_valid;
    logic                     rq0_ready;
    logic [`OPCODE_WIDTH-1:0] rq0_opcode;
    logic [`ALU_WIDTH-1:0]    rq0_alu;
    logic [DWIDTH-1:0]        rq0_data_rs1;
    logic [DWIDTH-1:0]        rq0_data_rs2;
    logic [DWIDTH-1:0]        rq0_imm;
    logic [PC_WIDTH-1:0]      rq0_pc;
    logic [AWIDTH-1:0]        rq0_addr_rd;

    logic                     rq1_valid;
    logic                     rq1_ready;
    logic [`OPCODE_WIDTH-1:0] rq1_opcode;
    logic [`ALU_WIDTH-1:0]    rq1_alu;
    logic [DWIDTH-1:0]        rq1_data_rs1;
    logic [DWIDTH-1:0]        rq1_data_rs2;
    logic [DWIDTH-1:0]        rq1_imm;
    logic [PC_WIDTH-1:0]      rq1_pc;
    logic [AWIDTH-1:0]        rq1_addr_rd;

    logic [`OPCODE_WIDTH-1:0] ex_o_opcode;
    logic [`ALU_WIDTH-1:0]    ex_o_alu;
    logic [DWIDTH-1:0]        ex_o_data_rs1;
    logic [DWIDTH-1:0]        ex_o_data_rs2;
    logic [DWIDTH-1:0]        ex_o_imm;
    logic [PC_WIDTH-1:0]      ex_o_pc;
    logic [DWIDTH-1:0]        alu_value;

    logic                     flush;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic                     rsp_id;
    logic [AWIDTH-1:0]        rsp_addr_rd;
    logic [DWIDTH-1:0]        rsp_data;
    logic                     busy;
    // Round-robin preference register, exposed for observation.
    logic                     prio;

    modport master (
        output rq0_valid, rq0_opcode, rq0_alu, rq0_data_rs1, rq0_data_rs2, rq0_imm, rq0_pc, rq0_addr_rd,
        output rq1_valid, rq1_opcode, rq1_alu, rq1_data_rs1, rq1_data_rs2, rq1_imm, rq1_pc, rq1_addr_rd,
        output alu_value, flush, rsp_ready,
        input  rq0_ready, rq1_ready,
        input  ex_o_opcode, ex_o_alu, ex_o_data_rs1, ex_o_data_rs2, ex_o_imm, ex_o_pc,
        input  rsp_valid, rsp_id, rsp_addr_rd, rsp_data, busy, prio
    );

    modport slave (
        input  rq0_valid, rq0_opcode, rq0_alu, rq0_data_rs1, rq0_data_rs2, rq0_imm, rq0_pc, rq0_addr_rd,
        input  rq1_valid, rq1_opcode, rq1_alu, rq1_data_rs1, rq1_data_rs2, rq1_imm, rq1_pc, rq1_addr_rd,
        input  alu_value, flush, rsp_ready,
        output rq0_ready, rq1_ready,
        output ex_o_opcode, ex_o_alu, ex_o_data_rs1, ex_o_data_rs2, ex_o_imm, ex_o_pc,
        output rsp_valid, rsp_id, rsp_addr_rd, rsp_data, busy, prio
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin sharing of one registered ALU between two requesters; the result returns
// one cycle after grant and stalls in place by feeding the ALU a zero op vector.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif

module alu_issue_arbiter #(
    parameter int DWIDTH   = 32,
    parameter int PC_WIDTH = 32,
    parameter int AWIDTH   = 5
) (
    input logic               clk,
    input logic               rst,
    alu_issue_arbiter_if.slave bus
);
    logic              prio_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [AWIDTH-1:0] rsp_addr_rd_q;

    logic can_issue;
    logic any_req;
    logic winner;
    logic grant;

    logic [`OPCODE_WIDTH-1:0] sel_opcode;
    logic [`ALU_WIDTH-1:0]    sel_alu;
    logic [DWIDTH-1:0]        sel_rs1;
    logic [DWIDTH-1:0]        sel_rs2;
    logic [DWIDTH-1:0]        sel_imm;
    logic [PC_WIDTH-1:0]      sel_pc;
    logic [AWIDTH-1:0]        sel_addr_rd;

    // A held result blocks issue because the ALU output register is the only result storage.
    always_comb begin
        can_issue = !rst && !bus.flush && (!rsp_valid_q || bus.rsp_ready);
        any_req   = bus.rq0_valid || bus.rq1_valid;
        winner    = (bus.rq0_valid && bus.rq1_valid) ? prio_q : bus.rq1_valid;
        grant     = can_issue && any_req;
    end

    always_comb begin
        sel_opcode  = '0;
        sel_alu     = '0;
        sel_rs1     = '0;
        sel_rs2     = '0;
        sel_imm     = '0;
        sel_pc      = '0;
        sel_addr_rd = '0;
        if (grant) begin
            if (winner) begin
                sel_opcode  = bus.rq1_opcode;
                sel_alu     = bus.rq1_alu;
                sel_rs1     = bus.rq1_data_rs1;
                sel_rs2     = bus.rq1_data_rs2;
                sel_imm     = bus.rq1_imm;
                sel_pc      = bus.rq1_pc;
                sel_addr_rd = bus.rq1_addr_rd;
            end else begin
                sel_opcode  = bus.rq0_opcode;
                sel_alu     = bus.rq0_alu;
                sel_rs1     = bus.rq0_data_rs1;
                sel_rs2     = bus.rq0_data_rs2;
                sel_imm     = bus.rq0_imm;
                sel_pc      = bus.rq0_pc;
                sel_addr_rd = bus.rq0_addr_rd;
            end
        end
    end

    assign bus.rq0_ready     = grant && !winner;
    assign bus.rq1_ready     = grant && winner;
    assign bus.ex_o_opcode   = sel_opcode;
    assign bus.ex_o_alu      = sel_alu;
    assign bus.ex_o_data_rs1 = sel_rs1;
    assign bus.ex_o_data_rs2 = sel_rs2;
    assign bus.ex_o_imm      = sel_imm;
    assign bus.ex_o_pc       = sel_pc;

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_addr_rd = rsp_addr_rd_q;
    assign bus.rsp_data    = bus.alu_value;
    assign bus.busy        = rsp_valid_q;
    assign bus.prio        = prio_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_addr_rd_q <= '0;
            prio_q        <= 1'b0;
        end else if (grant) begin
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= winner;
            rsp_addr_rd_q <= sel_addr_rd;
            prio_q        <= !winner;
        end else if (bus.rsp_ready || bus.flush) begin
            rsp_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: behavioural ALU, arbitration model and response scoreboard.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif
`timescale 1ns/1ps

module tb_alu_issue_arbiter;
    localparam int DW  = 32;
    localparam int PW  = 32;
    localparam int AW  = 5;
    localparam int OW  = `OPCODE_WIDTH;
    localparam int LW  = `ALU_WIDTH;
    localparam int SBW = 1 + AW + DW;
    localparam int A_ADD = 0, A_SUB = 1, A_XOR = 2, A_OR = 3, A_AND = 4;
    localparam int OP_R = 0, OP_I = 1;

    logic clk;
    logic rst;
    alu_issue_arbiter_if #(.DWIDTH(DW), .PC_WIDTH(PW), .AWIDTH(AW)) bus();
    alu_issue_arbiter #(.DWIDTH(DW), .PC_WIDTH(PW), .AWIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [SBW-1:0] exp_q[$];
    int   grant_port[$];
    int   grant_cyc[$];
    int   cyc = 0;
    logic m_valid = 1'b0;
    logic m_prio  = 1'b0;
    logic [DW-1:0] sub_data = '0;
    logic sub_seen = 1'b0;
    logic rand_run = 1'b0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] alu_f(input logic [LW-1:0] aop, input logic [OW-1:0] opc,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] imm);
        logic [DW-1:0] y;
        y = opc[OP_I] ? imm : b;
        alu_f = '0;
        if (aop[A_ADD])      alu_f = a + y;
        else if (aop[A_SUB]) alu_f = a - y;
        else if (aop[A_XOR]) alu_f = a ^ y;
        else if (aop[A_OR])  alu_f = a | y;
        else if (aop[A_AND]) alu_f = a & y;
    endfunction

    // Registered ALU: a zero op vector leaves the result untouched.
    always @(posedge clk) begin
        if (rst)
            bus.alu_value <= '0;
        else if (bus.ex_o_alu != '0)
            bus.alu_value <= alu_f(bus.ex_o_alu, bus.ex_o_opcode, bus.ex_o_data_rs1,
                                   bus.ex_o_data_rs2, bus.ex_o_imm);
    end

    // ---------------- arbitration model + scoreboard ----------------
    always @(negedge clk) begin : mon
        logic m_can, m_win, m_grant;
        logic [LW-1:0] m_alu;
        logic [SBW-1:0] got;
        logic [DW-1:0] m_data;
        logic [AW-1:0] m_tag;
        m_can   = !rst && !bus.flush && (!m_valid || bus.rsp_ready);
        m_win   = (bus.rq0_valid && bus.rq1_valid) ? m_prio : bus.rq1_valid;
        m_grant = m_can && (bus.rq0_valid || bus.rq1_valid);
        m_alu   = !m_grant ? '0 : (m_win ? bus.rq1_alu : bus.rq0_alu);
        check("mon_rdy0", bus.rq0_ready, m_grant && !m_win);
        check("mon_rdy1", bus.rq1_ready, m_grant && m_win);
        check("mon_ex_alu", bus.ex_o_alu, m_alu);
        check("mon_rsp_valid", bus.rsp_valid, m_valid);
        check("mon_busy", bus.busy, m_valid);
        if (bus.rq0_ready) begin grant_port.push_back(0); grant_cyc.push_back(cyc); end
        if (bus.rq1_ready) begin grant_port.push_back(1); grant_cyc.push_back(cyc); end

        if (bus.rsp_valid) begin
            got = {bus.rsp_id, bus.rsp_addr_rd, bus.rsp_data};
            check("sb_pending", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
                check("sb_rsp", got, exp_q[0]);
                if (bus.flush || bus.rsp_ready) void'(exp_q.pop_front());
            end
            if (!sub_seen && bus.rsp_ready && !bus.flush && bus.rsp_id && bus.rsp_addr_rd == AW'(9)) begin
                sub_data = bus.rsp_data;
                sub_seen = 1'b1;
            end
        end

        if (m_grant) begin
            if (m_win) begin
                m_data = alu_f(bus.rq1_alu, bus.rq1_opcode, bus.rq1_data_rs1, bus.rq1_data_rs2, bus.rq1_imm);
                m_tag  = bus.rq1_addr_rd;
            end else begin
                m_data = alu_f(bus.rq0_alu, bus.rq0_opcode, bus.rq0_data_rs1, bus.rq0_data_rs2, bus.rq0_imm);
                m_tag  = bus.rq0_addr_rd;
            end
            exp_q.push_back({m_win, m_tag, m_data});
        end

        if (rst) begin
            m_valid = 1'b0;
            m_prio  = 1'b0;
            exp_q.delete();
        end else if (m_grant) begin
            m_valid = 1'b1;
            m_prio  = !m_win;
        end else if (bus.rsp_ready || bus.flush) begin
            m_valid = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int port, input logic [LW-1:0] aop, input logic [OW-1:0] opc,
                             input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                             input logic [DW-1:0] imm, input logic [AW-1:0] tag);
        logic [PW-1:0] pc;
        pc = PW'($urandom);
        if (port == 0) begin
            bus.rq0_alu = aop; bus.rq0_opcode = opc; bus.rq0_data_rs1 = rs1;
            bus.rq0_data_rs2 = rs2; bus.rq0_imm = imm; bus.rq0_pc = pc;
            bus.rq0_addr_rd = tag; bus.rq0_valid = 1'b1;
        end else begin
            bus.rq1_alu = aop; bus.rq1_opcode = opc; bus.rq1_data_rs1 = rs1;
            bus.rq1_data_rs2 = rs2; bus.rq1_imm = imm; bus.rq1_pc = pc;
            bus.rq1_addr_rd = tag; bus.rq1_valid = 1'b1;
        end
    endtask

    task automatic wait_ready(input int port);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (port == 0) ? bus.rq0_ready : bus.rq1_ready;
        end
        check("wait_ready", seen, 1);
        step();
        if (port == 0) bus.rq0_valid = 1'b0;
        else           bus.rq1_valid = 1'b0;
    endtask

    task automatic issue(input int port, input logic [LW-1:0] aop, input logic [OW-1:0] opc,
                         input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                         input logic [DW-1:0] imm, input logic [AW-1:0] tag);
        drive_req(port, aop, opc, rs1, rs2, imm, tag);
        wait_ready(port);
    endtask

    function automatic logic [LW-1:0] onehot_alu(input int b);
        logic [LW-1:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [OW-1:0] onehot_opc(input int b);
        logic [OW-1:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.rq0_valid = 1'b0;
        bus.rq1_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        drive_req(0, onehot_alu(A_ADD), onehot_opc(OP_I), 32'd1, 32'd2, 32'd3, 5'd1);
        drive_req(1, onehot_alu(A_ADD), onehot_opc(OP_I), 32'd4, 32'd5, 32'd6, 5'd2);

        // Reset held two cycles with both ports requesting.
        repeat (2) begin
            @(negedge clk);
            check("rst_rdy0", bus.rq0_ready, 0);
            check("rst_rdy1", bus.rq1_ready, 0);
            check("rst_ex_alu", bus.ex_o_alu, 0);
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_rsp_id", bus.rsp_id, 0);
            check("rst_rsp_addr", bus.rsp_addr_rd, 0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_first_rdy0", bus.rq0_ready, 1);
        check("rst_first_rdy1", bus.rq1_ready, 0);
        step();
        bus.rq0_valid = 1'b0;
        @(negedge clk);
        check("rst_second_rdy1", bus.rq1_ready, 1);
        step();
        bus.rq1_valid = 1'b0;

        // Single ADD 5 + 7.
        issue(0, onehot_alu(A_ADD), onehot_opc(OP_I), 32'd5, 32'd0, 32'd7, 5'd3);
        @(negedge clk);
        check("add_valid", bus.rsp_valid, 1);
        check("add_data", bus.rsp_data, 12);
        check("add_id", bus.rsp_id, 0);
        check("add_addr", bus.rsp_addr_rd, 3);
        step();

        // Alternation: both ports busy every cycle, consumer always ready.
        grant_port.delete();
        grant_cyc.delete();
        fork
            begin
                issue(1, onehot_alu(A_SUB), onehot_opc(OP_R), 32'd10, 32'd4, 32'd0, 5'd9);
                repeat (3) issue(1, onehot_alu($urandom_range(0, 4)), onehot_opc($urandom_range(0, 1)),
                                 $urandom, $urandom, $urandom, AW'($urandom_range(12, 31)));
            end
            begin
                repeat (4) issue(0, onehot_alu($urandom_range(0, 4)), onehot_opc($urandom_range(0, 1)),
                                 $urandom, $urandom, $urandom, AW'($urandom_range(12, 31)));
            end
        join
        check("alt_count", grant_port.size(), 8);
        for (int i = 0; i < grant_port.size() && i < 8; i++) begin
            check("alt_port", grant_port[i], (i % 2 == 0) ? 1 : 0);
            if (i > 0) check("alt_gap", grant_cyc[i] - grant_cyc[i-1], 1);
        end
        check("alt_sub_seen", sub_seen, 1);
        check("alt_sub_data", sub_data, 6);
        step();

        // Backpressure on an XOR result with a port 0 request waiting behind it.
        bus.rsp_ready = 1'b0;
        issue(1, onehot_alu(A_XOR), onehot_opc(OP_R), 32'hF0, 32'h0F, 32'd0, 5'd4);
        drive_req(0, onehot_alu(A_ADD), onehot_opc(OP_I), 32'd100, 32'd0, 32'd23, 5'd7);
        repeat (4) begin
            @(negedge clk);
            check("bp_data", bus.rsp_data, 32'hFF);
            check("bp_id", bus.rsp_id, 1);
            check("bp_addr", bus.rsp_addr_rd, 4);
            check("bp_ex_alu", bus.ex_o_alu, 0);
            check("bp_rdy0", bus.rq0_ready, 0);
            check("bp_rdy1", bus.rq1_ready, 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_rdy0", bus.rq0_ready, 1);
        check("bp_release_valid", bus.rsp_valid, 1);
        step();
        bus.rq0_valid = 1'b0;

        // Flush while a result is stalled and port 0 waits.
        bus.rsp_ready = 1'b0;
        drive_req(0, onehot_alu(A_OR), onehot_opc(OP_I), 32'h30, 32'd0, 32'h0C, 5'd11);
        @(negedge clk);
        check("fl_pre_rdy0", bus.rq0_ready, 0);
        check("fl_pre_valid", bus.rsp_valid, 1);
        step();
        bus.flush = 1'b1;
        @(negedge clk);
        check("fl_rdy0", bus.rq0_ready, 0);
        check("fl_ex_alu", bus.ex_o_alu, 0);
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        check("fl_post_valid", bus.rsp_valid, 0);
        check("fl_post_rdy0", bus.rq0_ready, 1);
        step();
        bus.rq0_valid = 1'b0;

        // Reset while the OR result is stalled.
        @(negedge clk);
        check("ms_pre_valid", bus.rsp_valid, 1);
        check("ms_pre_data", bus.rsp_data, 32'h3C);
        step();
        rst = 1'b1;
        drive_req(0, onehot_alu(A_AND), onehot_opc(OP_R), 32'hFF, 32'h3C, 32'd0, 5'd13);
        drive_req(1, onehot_alu(A_SUB), onehot_opc(OP_I), 32'd50, 32'd0, 32'd8, 5'd14);
        @(negedge clk);
        check("ms_rst_rdy0", bus.rq0_ready, 0);
        check("ms_rst_rdy1", bus.rq1_ready, 0);
        check("ms_rst_ex_alu", bus.ex_o_alu, 0);
        step();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("ms_valid", bus.rsp_valid, 0);
        check("ms_busy", bus.busy, 0);
        check("ms_prio", bus.prio, 0);
        check("ms_addr", bus.rsp_addr_rd, 0);
        check("ms_rdy0", bus.rq0_ready, 1);
        check("ms_rdy1", bus.rq1_ready, 0);
        step();
        bus.rq0_valid = 1'b0;
        wait_ready(1);

        // Random traffic with random consumer stalls and occasional flushes.
        rand_run = 1'b1;
        fork
            begin
                while (rand_run) begin
                    step();
                    bus.rsp_ready = ($urandom_range(0, 3) != 0);
                    bus.flush     = ($urandom_range(0, 15) == 0);
                end
                bus.rsp_ready = 1'b1;
                bus.flush     = 1'b0;
            end
        join_none
        fork
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 2)) step();
                    issue(0, onehot_alu($urandom_range(0, 4)), onehot_opc($urandom_range(0, 1)),
                          $urandom, $urandom, $urandom, AW'($urandom));
                end
            end
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 2)) step();
                    issue(1, onehot_alu($urandom_range(0, 4)), onehot_opc($urandom_range(0, 1)),
                          $urandom, $urandom, $urandom, AW'($urandom));
                end
            end
        join
        rand_run = 1'b0;
        repeat (4) step();
        check("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
